alu_sequencer: RTL and testbench
================================

# alu_sequencer

Sequences operations through the 16-bit ALU controller datapath (AND / OR / ADD / SUB result mux). It accepts operation commands over a valid/ready handshake and buffers up to two commands. It drives the ALU's `Control` select and operand registers, waits a fixed ALU latency and captures the selected result. It returns each result over a second valid/ready handshake and keeps a running accumulator so chained operations need no external operand.

## Interface
- `WIDTH`, 16, datapath width; matches ALU operand/result width.
- `ALU_LAT`, 1, cycles from registered Control/operands to a valid `AluResult`; legal range 1..7.
- `Clk`  in  1  single clock, rising edge.
- `nReset`  in  1  asynchronous, active-low reset.
- `CmdValid`  in  1  command offered.
- `CmdReady`  out  1  FIFO can accept; equals (count < 2).
- `CmdOp`  in  2  00 AND, 01 OR, 10 ADD, 11 SUB; driven unchanged onto `Control`.
- `CmdAcc`  in  1  1: operand A = accumulator; 0: operand A = `CmdA`.
- `CmdA`  in  WIDTH  operand A.
- `CmdB`  in  WIDTH  operand B.
- `AccClr`  in  1  synchronous accumulator clear.
- `Control`  out  2  to ALU controller select, registered.
- `OperandA`  out  WIDTH  to ALU, registered.
- `OperandB`  out  WIDTH  to ALU, registered.
- `AluResult`  in  WIDTH  ALU controller output.
- `RspValid`  out  1  result available.
- `RspReady`  in  1  consumer accepts result.
- `RspData`  out  WIDTH  captured result.
- `RspZero`  out  1  `RspData` == 0.
- `Busy`  out  1  state ≠ IDLE or FIFO non-empty.

## Operation
- Command FIFO: depth 2, stores {op, acc, A, B}.
  - Push on `CmdValid && CmdReady`. `CmdReady` comes from the registered count only.
  - Push and pop in the same cycle leave the count unchanged.
- FSM states: IDLE, EXEC, RESP.
- IDLE: if the FIFO is non-empty, pop the head and load the outputs:
  - `Control` ← op.
  - `OperandA` ← (acc ? Acc : A).
  - `OperandB` ← B.
  - cnt ← ALU_LAT−1.
  - Next state EXEC.
- EXEC: if cnt ≠ 0, decrement. If cnt = 0:
  - `RspData` ← `AluResult`, `RspZero` ← (`AluResult` == 0), Acc ← `AluResult`.
  - `RspValid` ← 1, next state RESP.
- RESP: hold `RspData`/`RspZero`/`RspValid` until `RspReady`. On handshake: `RspValid` ← 0, next state IDLE.
- `Control`, `OperandA`, `OperandB` hold their last values outside IDLE-pop; they are never returned to 0.
- Arithmetic is performed entirely by the ALU; no width growth; carry is not observed.
- `AccClr`: Acc ← 0 at the next edge. If it coincides with an EXEC capture, the capture wins.
  - An accumulator-sourced pop in the same cycle as `AccClr` uses the pre-clear Acc value.
- Reset (any time, including mid-operation):
  - FIFO emptied (`CmdReady` = 1), state IDLE.
  - `Control` = 00; `OperandA` = `OperandB` = 0; Acc = 0.
  - `RspValid` = 0, `RspData` = 0, `RspZero` = 1, `Busy` = 0.
  - In-flight commands are discarded.

## Timing
- Accept at edge E0 into an empty, idle block:
  - Pop and operands registered at E1.
  - Result captured at E1+ALU_LAT.
  - `RspValid` high from that edge.
  - With ALU_LAT=1, `RspValid` rises 2 edges after accept.
- Minimum issue interval with `RspReady` tied high: ALU_LAT+2 cycles per command (one bubble in IDLE).
- A third command stalls with `CmdReady` = 0 while two are buffered. `CmdReady` rises the cycle after the pop edge.
- A consumer holding `RspReady` low stalls the FSM in RESP indefinitely. FIFO contents are preserved and Acc is unchanged.
- `RspValid` never drops without a handshake; `RspData` is stable while `RspValid`=1.

## Test plan
- Reset, then single ADD A=0x0003 B=0x0004, `RspReady`=1:
  - `Control`=10 at E1.
  - `RspData`=0x0007, `RspZero`=0, `RspValid` high after E2.
- SUB A=0x0005 B=0x0005:
  - `Control`=11, `RspData`=0x0000, `RspZero`=1.
  - Acc=0.
- Chain:
  - AND A=0xF0F0 B=0x0FF0 → 0x00F0.
  - Then OR acc=1 B=0x000F → `OperandA`=0x00F0, result 0x00FF.
- Back-pressure:
  - Hold `RspReady`=0, push 3 commands.
  - `CmdReady`=0 after the second buffered push; the third command is accepted only after the first pop.
  - All three results return in order once `RspReady`=1.
- `AccClr` asserted on the same edge as an EXEC capture of 0x1234 → Acc=0x1234. `AccClr` next cycle → Acc=0.
- Assert `nReset` low mid-EXEC with ALU_LAT=3:
  - All outputs return to their reset values immediately.
  - After release, no stale `RspValid`; a new ADD 1+1 returns 0x0002.

Source files
------------

// File: rtl/alu_sequencer.sv
// Command sequencer for the 16-bit AND/OR/ADD/SUB ALU controller: two-deep command
// FIFO, Control/operand registers, fixed-latency result capture and a running accumulator.
`timescale 1ns/1ps
module alu_sequencer #(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic [1:0]       CmdOp,
  input  logic             CmdAcc,
  input  logic [WIDTH-1:0] CmdA,
  input  logic [WIDTH-1:0] CmdB,
  input  logic             AccClr,
  output logic [1:0]       Control,
  output logic [WIDTH-1:0] OperandA,
  output logic [WIDTH-1:0] OperandB,
  input  logic [WIDTH-1:0] AluResult,
  output logic             RspValid,
  input  logic             RspReady,
  output logic [WIDTH-1:0] RspData,
  output logic             RspZero,
  output logic             Busy
);

  localparam int         ENTRY_W  = 3 + 2 * WIDTH;
  localparam logic [2:0] CNT_INIT = 3'(ALU_LAT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state;
  logic [ENTRY_W-1:0] fifo_mem [2];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         count;
  logic [2:0]         cnt;
  logic [WIDTH-1:0]   acc;
  logic               push;
  logic               pop;
  logic [1:0]         head_op;
  logic               head_acc;
  logic [WIDTH-1:0]   head_a;
  logic [WIDTH-1:0]   head_b;

  assign CmdReady = (count < 2'd2);
  assign push     = CmdValid && CmdReady;
  assign pop      = (state == IDLE) && (count != 2'd0);
  assign Busy     = (state != IDLE) || (count != 2'd0);
  assign {head_op, head_acc, head_a, head_b} = fifo_mem[rd_ptr];

  // Queue storage carries data only; occupancy is tracked by the pointers and count.
  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {CmdOp, CmdAcc, CmdA, CmdB};
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // The clear is placed first so a capture in the same cycle overrides it, while an
  // accumulator-sourced pop still reads the pre-clear value.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      Control  <= 2'b00;
      OperandA <= '0;
      OperandB <= '0;
      acc      <= '0;
      RspValid <= 1'b0;
      RspData  <= '0;
      RspZero  <= 1'b1;
    end else begin
      if (AccClr) acc <= '0;
      case (state)
        IDLE: begin
          if (pop) begin
            Control  <= head_op;
            OperandA <= head_acc ? acc : head_a;
            OperandB <= head_b;
            cnt      <= CNT_INIT;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            RspData  <= AluResult;
            RspZero  <= (AluResult == '0);
            acc      <= AluResult;
            RspValid <= 1'b1;
            state    <= RESP;
          end
        end
        RESP: begin
          if (RspReady) begin
            RspValid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: one instance with ALU_LAT=1, one with ALU_LAT=3, each driving
// a behavioural ALU; directed scenarios plus a randomized run against an in-order model.
`timescale 1ns/1ps
module tb_alu_sequencer;
  localparam int W = 16;

  typedef struct packed {
    logic [1:0]   op;
    logic         acc;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } cmd_t;

  logic Clk = 1'b0;
  logic nReset;
  always #5 Clk = ~Clk;

  logic         cmd_valid, cmd_ready, cmd_acc, acc_clr, rsp_valid, rsp_ready, rsp_zero, busy;
  logic [1:0]   cmd_op, control;
  logic [W-1:0] cmd_a, cmd_b, op_a, op_b, alu_result, rsp_data;

  logic         cmd_valid3, cmd_ready3, cmd_acc3, acc_clr3, rsp_valid3, rsp_ready3, rsp_zero3, busy3;
  logic [1:0]   cmd_op3, control3;
  logic [W-1:0] cmd_a3, cmd_b3, op_a3, op_b3, alu_result3, rsp_data3;
  logic [W-1:0] alu3_s1, alu3_s2;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] m_acc;

  alu_sequencer #(.WIDTH(W), .ALU_LAT(1)) u_dut (
    .Clk(Clk), .nReset(nReset), .CmdValid(cmd_valid), .CmdReady(cmd_ready), .CmdOp(cmd_op),
    .CmdAcc(cmd_acc), .CmdA(cmd_a), .CmdB(cmd_b), .AccClr(acc_clr), .Control(control),
    .OperandA(op_a), .OperandB(op_b), .AluResult(alu_result), .RspValid(rsp_valid),
    .RspReady(rsp_ready), .RspData(rsp_data), .RspZero(rsp_zero), .Busy(busy)
  );

  alu_sequencer #(.WIDTH(W), .ALU_LAT(3)) u_dut3 (
    .Clk(Clk), .nReset(nReset), .CmdValid(cmd_valid3), .CmdReady(cmd_ready3), .CmdOp(cmd_op3),
    .CmdAcc(cmd_acc3), .CmdA(cmd_a3), .CmdB(cmd_b3), .AccClr(acc_clr3), .Control(control3),
    .OperandA(op_a3), .OperandB(op_b3), .AluResult(alu_result3), .RspValid(rsp_valid3),
    .RspReady(rsp_ready3), .RspData(rsp_data3), .RspZero(rsp_zero3), .Busy(busy3)
  );

  function automatic logic [W-1:0] alu_f(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a + b;
      default: return a - b;
    endcase
  endfunction

  // ALU behaviour: combinational for latency 1, two extra register stages for latency 3.
  assign alu_result = alu_f(control, op_a, op_b);
  always @(posedge Clk) begin
    alu3_s1 <= alu_f(control3, op_a3, op_b3);
    alu3_s2 <= alu3_s1;
  end
  assign alu_result3 = alu3_s2;

  task automatic send_cmd(input bit d3, input logic [1:0] op, input logic acc,
                          input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    @(negedge Clk);
    if (d3) begin cmd_valid3 = 1; cmd_op3 = op; cmd_acc3 = acc; cmd_a3 = a; cmd_b3 = b; end
    else    begin cmd_valid  = 1; cmd_op  = op; cmd_acc  = acc; cmd_a  = a; cmd_b  = b; end
    while (!(d3 ? cmd_ready3 : cmd_ready) && n < 100) begin @(negedge Clk); n++; end
    n_checks++;
    if (n >= 100) begin n_fail++; $display("FAIL send_timeout: CmdReady low for %0d cycles, required 1", n); end
    @(posedge Clk); #1;
    if (d3) cmd_valid3 = 0; else cmd_valid = 0;
  endtask

  task automatic get_rsp(input bit d3, output logic [W-1:0] d, output logic z, output bit ok);
    int n = 0;
    if (d3) rsp_ready3 = 1; else rsp_ready = 1;
    while (!(d3 ? rsp_valid3 : rsp_valid) && n < 100) begin @(negedge Clk); n++; end
    ok = (n < 100);
    d  = d3 ? rsp_data3 : rsp_data;
    z  = d3 ? rsp_zero3 : rsp_zero;
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmdready: got %b want 1", cmd_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rspvalid: got %b want 0", rsp_valid); end
    n_checks++; if (rsp_data !== 16'h0) begin n_fail++; $display("FAIL rst_rspdata: got %h want 0000", rsp_data); end
    n_checks++; if (rsp_zero !== 1'b1) begin n_fail++; $display("FAIL rst_rspzero: got %b want 1", rsp_zero); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (control !== 2'b00) begin n_fail++; $display("FAIL rst_control: got %b want 00", control); end
    n_checks++; if (op_a !== 16'h0 || op_b !== 16'h0) begin n_fail++; $display("FAIL rst_operands: got %h/%h want 0000/0000", op_a, op_b); end
    n_checks++; if (cmd_ready3 !== 1'b1 || rsp_valid3 !== 1'b0) begin n_fail++; $display("FAIL rst_dut3: got ready %b valid %b want 1 0", cmd_ready3, rsp_valid3); end
  endtask

  task automatic test_single_add();
    rsp_ready = 1;
    send_cmd(0, 2'b10, 0, 16'h0003, 16'h0004);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL add_busy: got %b want 1", busy); end
    @(posedge Clk); #1;
    n_checks++; if (control !== 2'b10) begin n_fail++; $display("FAIL add_control: got %b want 10", control); end
    n_checks++; if (op_a !== 16'h0003 || op_b !== 16'h0004) begin n_fail++; $display("FAIL add_operands: got %h/%h want 0003/0004", op_a, op_b); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_early_valid: got %b want 0", rsp_valid); end
    @(posedge Clk); #1;
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid_e2: got %b want 1", rsp_valid); end
    n_checks++; if (rsp_data !== 16'h0007 || rsp_zero !== 1'b0) begin n_fail++; $display("FAIL add_result: got %h z%b want 0007 z0", rsp_data, rsp_zero); end
    @(posedge Clk); #1;
    n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL add_retire: got valid %b busy %b want 0 0", rsp_valid, busy); end
    m_acc = 16'h0007;
  endtask

  task automatic test_sub_zero();
    logic [W-1:0] d; logic z; bit ok;
    send_cmd(0, 2'b11, 0, 16'h0005, 16'h0005);
    @(posedge Clk); #1;
    n_checks++; if (control !== 2'b11) begin n_fail++; $display("FAIL sub_control: got %b want 11", control); end
    get_rsp(0, d, z, ok);
    n_checks++; if (!ok || d !== 16'h0000 || z !== 1'b1) begin n_fail++; $display("FAIL sub_result: got %h z%b ok%b want 0000 z1 ok1", d, z, ok); end
    send_cmd(0, 2'b10, 1, 16'hFFFF, 16'h0009);
    @(posedge Clk); #1;
    n_checks++; if (op_a !== 16'h0000) begin n_fail++; $display("FAIL sub_acc_zero: got %h want 0000", op_a); end
    get_rsp(0, d, z, ok);
    n_checks++; if (!ok || d !== 16'h0009) begin n_fail++; $display("FAIL sub_acc_add: got %h want 0009", d); end
  endtask

  task automatic test_chain();
    logic [W-1:0] d; logic z; bit ok;
    send_cmd(0, 2'b00, 0, 16'hF0F0, 16'h0FF0);
    get_rsp(0, d, z, ok);
    n_checks++; if (!ok || d !== 16'h00F0) begin n_fail++; $display("FAIL chain_and: got %h want 00F0", d); end
    send_cmd(0, 2'b01, 1, 16'hAAAA, 16'h000F);
    @(posedge Clk); #1;
    n_checks++; if (op_a !== 16'h00F0) begin n_fail++; $display("FAIL chain_opa: got %h want 00F0", op_a); end
    get_rsp(0, d, z, ok);
    n_checks++; if (!ok || d !== 16'h00FF || z !== 1'b0) begin n_fail++; $display("FAIL chain_or: got %h z%b want 00FF z0", d, z); end
  endtask

  task automatic test_acc_clr();
    logic [W-1:0] d; logic z; bit ok;
    send_cmd(0, 2'b10, 0, 16'h1230, 16'h0004);
    @(posedge Clk); #1; acc_clr = 1;
    @(posedge Clk); #1; acc_clr = 0;
    get_rsp(0, d, z, ok);
    n_checks++; if (!ok || d !== 16'h1234) begin n_fail++; $display("FAIL clr_capture: got %h want 1234", d); end
    send_cmd(0, 2'b01, 1, 16'h0000, 16'h0000);
    acc_clr = 1;
    @(posedge Clk); #1; acc_clr = 0;
    n_checks++; if (op_a !== 16'h1234) begin n_fail++; $display("FAIL clr_capture_wins: got %h want 1234", op_a); end
    get_rsp(0, d, z, ok);
    n_checks++; if (!ok || d !== 16'h1234) begin n_fail++; $display("FAIL clr_preclear_pop: got %h want 1234", d); end
    @(negedge Clk); acc_clr = 1;
    @(negedge Clk); acc_clr = 0;
    send_cmd(0, 2'b10, 1, 16'hFFFF, 16'h0005);
    @(posedge Clk); #1;
    n_checks++; if (op_a !== 16'h0000) begin n_fail++; $display("FAIL clr_idle: got %h want 0000", op_a); end
    get_rsp(0, d, z, ok);
    n_checks++; if (!ok || d !== 16'h0005) begin n_fail++; $display("FAIL clr_after: got %h want 0005", d); end
  endtask

  task automatic test_back_pressure();
    logic [W-1:0] d; logic z; bit ok;
    logic [W-1:0] exp_q[$];
    exp_q = '{16'h0002, 16'h0005, 16'h000F, 16'h00A5};
    rsp_ready = 0;
    send_cmd(0, 2'b10, 0, 16'h0001, 16'h0001);
    send_cmd(0, 2'b10, 0, 16'h0002, 16'h0003);
    send_cmd(0, 2'b11, 0, 16'h0010, 16'h0001);
    repeat (3) @(posedge Clk); #1;
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: got CmdReady %b want 0", cmd_ready); end
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0002) begin n_fail++; $display("FAIL bp_hold: got %b/%h want 1/0002", rsp_valid, rsp_data); end
    fork
      send_cmd(0, 2'b00, 0, 16'hFFFF, 16'h00A5);
    join_none
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      n_checks++; if (cmd_ready !== 1'b0 || rsp_data !== 16'h0002) begin n_fail++; $display("FAIL bp_stall: got ready %b data %h want 0 0002", cmd_ready, rsp_data); end
    end
    for (int i = 0; i < 4; i++) begin
      get_rsp(0, d, z, ok);
      n_checks++; if (!ok || d !== exp_q[i]) begin n_fail++; $display("FAIL bp_order%0d: got %h want %h", i, d, exp_q[i]); end
    end
    m_acc = 16'h00A5;
  endtask

  task automatic test_random();
    cmd_t q[$];
    cmd_t c;
    logic [W-1:0] exp, prev_data;
    logic prev_hold;
    int got, cyc;
    @(negedge Clk); acc_clr = 1;
    @(negedge Clk); acc_clr = 0;
    m_acc = '0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          cmd_t nc;
          repeat ($urandom_range(0, 3)) @(negedge Clk);
          nc.op  = 2'($urandom_range(0, 3));
          nc.acc = ($urandom_range(0, 2) == 0);
          nc.a   = 16'($urandom);
          nc.b   = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
          if (nc.op == 2'b11 && $urandom_range(0, 3) == 0) nc.a = nc.b;
          send_cmd(0, nc.op, nc.acc, nc.a, nc.b);
          q.push_back(nc);
        end
      end
      begin
        got = 0; cyc = 0; prev_hold = 0; prev_data = '0;
        while (got < 40 && cyc < 3000) begin
          logic rr;
          @(negedge Clk); cyc++;
          if (prev_hold) begin
            n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== prev_data) begin n_fail++; $display("FAIL rnd_stable: got %b/%h want 1/%h", rsp_valid, rsp_data, prev_data); end
          end
          rr = 1'($urandom_range(0, 1));
          rsp_ready = rr;
          prev_hold = rsp_valid && !rr;
          prev_data = rsp_data;
          if (rsp_valid && rr) begin
            n_checks++;
            if (q.size() == 0) begin
              n_fail++; $display("FAIL rnd_unexpected: response %h with no command outstanding", rsp_data);
            end else begin
              c = q.pop_front();
              exp = alu_f(c.op, c.acc ? m_acc : c.a, c.b);
              m_acc = exp;
              if (rsp_data !== exp || rsp_zero !== (exp == 16'h0)) begin n_fail++; $display("FAIL rnd_result%0d: got %h z%b want %h z%b", got, rsp_data, rsp_zero, exp, exp == 16'h0); end
            end
            got++;
          end
        end
        n_checks++; if (got != 40) begin n_fail++; $display("FAIL rnd_count: got %0d responses want 40", got); end
        rsp_ready = 1;
      end
    join
  endtask

  task automatic test_reset_mid_exec();
    logic [W-1:0] d; logic z; bit ok;
    rsp_ready3 = 1;
    send_cmd(1, 2'b10, 0, 16'h0100, 16'h0200);
    @(posedge Clk); #1;
    n_checks++; if (control3 !== 2'b10 || busy3 !== 1'b1) begin n_fail++; $display("FAIL mid_exec: got ctl %b busy %b want 10 1", control3, busy3); end
    @(posedge Clk); #2;
    nReset = 0;
    #1;
    n_checks++; if (control3 !== 2'b00 || op_a3 !== 16'h0 || op_b3 !== 16'h0) begin n_fail++; $display("FAIL mid_rst_regs: got %b %h %h want 00 0000 0000", control3, op_a3, op_b3); end
    n_checks++; if (rsp_valid3 !== 1'b0 || rsp_data3 !== 16'h0 || rsp_zero3 !== 1'b1) begin n_fail++; $display("FAIL mid_rst_rsp: got %b %h %b want 0 0000 1", rsp_valid3, rsp_data3, rsp_zero3); end
    n_checks++; if (busy3 !== 1'b0 || cmd_ready3 !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ctl: got busy %b ready %b want 0 1", busy3, cmd_ready3); end
    @(negedge Clk); nReset = 1;
    repeat (6) @(negedge Clk);
    n_checks++; if (rsp_valid3 !== 1'b0 || busy3 !== 1'b0) begin n_fail++; $display("FAIL mid_stale: got valid %b busy %b want 0 0", rsp_valid3, busy3); end
    send_cmd(1, 2'b10, 0, 16'h0001, 16'h0001);
    repeat (3) @(posedge Clk); #1;
    n_checks++; if (rsp_valid3 !== 1'b0) begin n_fail++; $display("FAIL lat3_early: got %b want 0", rsp_valid3); end
    @(posedge Clk); #1;
    n_checks++; if (rsp_valid3 !== 1'b1) begin n_fail++; $display("FAIL lat3_valid: got %b want 1", rsp_valid3); end
    get_rsp(1, d, z, ok);
    n_checks++; if (!ok || d !== 16'h0002 || z !== 1'b0) begin n_fail++; $display("FAIL lat3_result: got %h z%b want 0002 z0", d, z); end
  endtask

  initial begin
    nReset = 0;
    cmd_valid = 0; cmd_op = '0; cmd_acc = 0; cmd_a = '0; cmd_b = '0; acc_clr = 0; rsp_ready = 0;
    cmd_valid3 = 0; cmd_op3 = '0; cmd_acc3 = 0; cmd_a3 = '0; cmd_b3 = '0; acc_clr3 = 0; rsp_ready3 = 0;
    m_acc = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk); nReset = 1;
    @(negedge Clk);
    test_reset();
    test_single_add();
    test_sub_zero();
    test_chain();
    test_acc_clr();
    test_back_pressure();
    test_random();
    test_reset_mid_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
